// File: rtl/dma_io_pkg.sv
// Shared types for the floppy/ACSI IO-controller channel scheduler: FSM states,
// owner codes, io_status bit layout and the round-robin pick.
package dma_io_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_ACK     = 2'd2,
    ST_HOLDOFF = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'b00,
    OWN_FDC  = 2'b01,
    OWN_ACSI = 2'b10
  } owner_e;

  // io_status = {busy, timeout_err, owner[1:0], last_owner[1:0], 2'b00}
  localparam int STAT_BUSY_BIT  = 7;
  localparam int STAT_TERR_BIT  = 6;
  localparam int STAT_OWNER_LSB = 4;
  localparam int STAT_LAST_LSB  = 2;

  // Quiet cycles after an ack so the served requester can drop its level.
  localparam int HOLDOFF_CYCLES = 2;

  // On a tie the requester that was not served last wins.
  function automatic owner_e rr_pick(input logic fdc, input logic acsi,
                                     input owner_e last);
    owner_e pick;
    pick = OWN_NONE;
    if (fdc && acsi) begin
      if (last == OWN_FDC) pick = OWN_ACSI;
      else                 pick = OWN_FDC;
    end else if (fdc) begin
      pick = OWN_FDC;
    end else if (acsi) begin
      pick = OWN_ACSI;
    end
    return pick;
  endfunction

endpackage

// File: rtl/io_timeout_cnt.sv
// Grant-age counter; expired is high while the count sits at TIMEOUT_CYCLES-1.
module io_timeout_cnt #(
  parameter int TIMEOUT_CYCLES = 8000000,
  parameter int TIMER_W        = 24
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [TIMER_W-1:0] LAST_COUNT = TIMER_W'(TIMEOUT_CYCLES - 1);

  logic [TIMER_W-1:0] count_q;

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every flop samples the pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count_q <= '0;
    end else if (enable) begin
      count_q <= count_q + TIMER_W'(1);
    end
  end

  assign expired = (count_q == LAST_COUNT);

endmodule

// File: rtl/dma_io_sched.sv
// Round-robin owner of the single IO-controller transfer channel shared by the
// FDC and ACSI controllers, with completion ack pulses and a grant timeout.
module dma_io_sched
  import dma_io_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 8000000,
  parameter int TIMER_W        = 24
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       fdc_req,
  output logic       fdc_ack,
  input  logic       acsi_req,
  output logic       acsi_ack,
  input  logic       io_strobe,
  output logic [1:0] io_owner,
  output logic       io_busy,
  output logic       timeout_err,
  output logic [7:0] io_status
);

  state_e state_q, state_d;
  owner_e owner_q, owner_d;
  owner_e last_q, last_d;
  owner_e grant_sel;
  logic   busy_q, busy_d;
  logic   terr_q, terr_d;
  logic   fdc_ack_q, fdc_ack_d;
  logic   acsi_ack_q, acsi_ack_d;
  logic   hold_q, hold_d;
  logic   owner_req;
  logic   tmr_clear, tmr_en, tmr_expired;

  assign grant_sel = rr_pick(fdc_req, acsi_req, last_q);
  assign owner_req = (owner_q == OWN_FDC) ? fdc_req : acsi_req;
  assign tmr_en    = (state_q == ST_GRANT);
  assign tmr_clear = !tmr_en;

  io_timeout_cnt #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .TIMER_W       (TIMER_W)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (tmr_clear),
    .enable (tmr_en),
    .expired(tmr_expired)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // NOTE: every signal driven here gets a default before the case statement,
  // which keeps the block purely combinational (no latches on missed paths).
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    last_d     = last_q;
    busy_d     = busy_q;
    terr_d     = terr_q;
    hold_d     = hold_q;
    fdc_ack_d  = 1'b0;
    acsi_ack_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (grant_sel != OWN_NONE) begin
          owner_d = grant_sel;
          busy_d  = 1'b1;
          terr_d  = 1'b0;
          state_d = ST_GRANT;
        end
      end
      ST_GRANT: begin
        // A real completion beats both the timeout and a dropped request.
        if (io_strobe || tmr_expired) begin
          terr_d     = !io_strobe;
          fdc_ack_d  = (owner_q == OWN_FDC);
          acsi_ack_d = (owner_q == OWN_ACSI);
          state_d    = ST_ACK;
        end else if (!owner_req) begin
          owner_d = OWN_NONE;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end
      ST_ACK: begin
        last_d  = owner_q;
        owner_d = OWN_NONE;
        busy_d  = 1'b0;
        hold_d  = 1'b0;
        state_d = ST_HOLDOFF;
      end
      ST_HOLDOFF: begin
        if (hold_q == 1'(HOLDOFF_CYCLES - 1)) state_d = ST_IDLE;
        else                                  hold_d  = hold_q + 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      owner_q    <= OWN_NONE;
      last_q     <= OWN_ACSI;
      busy_q     <= 1'b0;
      terr_q     <= 1'b0;
      hold_q     <= 1'b0;
      fdc_ack_q  <= 1'b0;
      acsi_ack_q <= 1'b0;
    end else begin
      owner_q    <= owner_d;
      last_q     <= last_d;
      busy_q     <= busy_d;
      terr_q     <= terr_d;
      hold_q     <= hold_d;
      fdc_ack_q  <= fdc_ack_d;
      acsi_ack_q <= acsi_ack_d;
    end
  end

  assign io_owner    = owner_q;
  assign io_busy     = busy_q;
  assign timeout_err = terr_q;
  assign fdc_ack     = fdc_ack_q;
  assign acsi_ack    = acsi_ack_q;

  always_comb begin
    io_status                         = '0;
    io_status[STAT_BUSY_BIT]          = busy_q;
    io_status[STAT_TERR_BIT]          = terr_q;
    io_status[STAT_OWNER_LSB +: 2]    = owner_q;
    io_status[STAT_LAST_LSB +: 2]     = last_q;
  end

endmodule

// File: tb/tb_dma_io_sched.sv
// Self-checking bench for dma_io_sched: directed scenarios plus a randomized run
// compared each cycle against a transaction-level model of the scheduler.
module tb_dma_io_sched;

  localparam int T = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       fdc_req = 1'b0;
  logic       acsi_req = 1'b0;
  logic       io_strobe = 1'b0;
  logic       fdc_ack, acsi_ack, io_busy, timeout_err;
  logic [1:0] io_owner;
  logic [7:0] io_status;

  int n_checks = 0;
  int n_pass   = 0;

  // Model: owner/last as 0 none, 1 FDC, 2 ACSI; m_ack marks the ack cycle;
  // m_quiet counts remaining quiet cycles after an ack; m_age is grant age.
  int m_owner = 0;
  int m_last  = 2;
  int m_ack   = 0;
  int m_quiet = 0;
  int m_age   = 0;
  bit m_terr  = 1'b0;

  dma_io_sched #(.TIMEOUT_CYCLES(T), .TIMER_W(5)) dut (
    .clk        (clk),
    .reset      (reset),
    .fdc_req    (fdc_req),
    .fdc_ack    (fdc_ack),
    .acsi_req   (acsi_req),
    .acsi_ack   (acsi_ack),
    .io_strobe  (io_strobe),
    .io_owner   (io_owner),
    .io_busy    (io_busy),
    .timeout_err(timeout_err),
    .io_status  (io_status)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic model_step();
    if (reset) begin
      m_owner = 0; m_last = 2; m_terr = 1'b0; m_ack = 0; m_quiet = 0; m_age = 0;
    end else if (m_ack != 0) begin
      m_last = m_ack; m_ack = 0; m_owner = 0; m_quiet = 2;
    end else if (m_quiet > 0) begin
      m_quiet--;
    end else if (m_owner == 0) begin
      if (fdc_req && acsi_req) m_owner = (m_last == 1) ? 2 : 1;
      else if (fdc_req)        m_owner = 1;
      else if (acsi_req)       m_owner = 2;
      if (m_owner != 0) begin m_age = 0; m_terr = 1'b0; end
    end else begin
      m_age++;
      if (io_strobe || m_age == T) begin
        m_ack  = m_owner;
        m_terr = !io_strobe;
      end else if (!((m_owner == 1) ? fdc_req : acsi_req)) begin
        m_owner = 0;
      end
    end
  endtask

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic settle();
    fdc_req = 1'b0; acsi_req = 1'b0; io_strobe = 1'b0;
    repeat (6) tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    n_checks++; if (io_owner !== 2'b00) $display("FAIL reset_owner: got %b want 00", io_owner); else n_pass++;
    n_checks++; if (io_busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", io_busy); else n_pass++;
    n_checks++; if ({fdc_ack, acsi_ack} !== 2'b00) $display("FAIL reset_acks: got %b%b want 00", fdc_ack, acsi_ack); else n_pass++;
    n_checks++; if (timeout_err !== 1'b0) $display("FAIL reset_terr: got %b want 0", timeout_err); else n_pass++;
    n_checks++; if (io_status !== 8'b0000_1000) $display("FAIL reset_status: got %b want 00001000", io_status); else n_pass++;
    reset = 1'b0;
  endtask

  task automatic test_fdc_only();
    logic seen_early = 1'b0;
    logic seen_acsi  = 1'b0;
    fdc_req = 1'b1;
    tick();
    n_checks++; if (io_owner !== 2'b01) $display("FAIL fdc_grant_owner: got %b want 01", io_owner); else n_pass++;
    n_checks++; if (io_busy !== 1'b1) $display("FAIL fdc_grant_busy: got %b want 1", io_busy); else n_pass++;
    repeat (4) begin
      tick();
      seen_early |= fdc_ack | acsi_ack;
    end
    n_checks++; if (seen_early !== 1'b0) $display("FAIL fdc_early_ack: got %b want 0", seen_early); else n_pass++;
    io_strobe = 1'b1;
    tick();
    io_strobe = 1'b0;
    seen_acsi |= acsi_ack;
    n_checks++; if (fdc_ack !== 1'b1) $display("FAIL fdc_ack_rise: got %b want 1", fdc_ack); else n_pass++;
    n_checks++; if (io_busy !== 1'b1) $display("FAIL fdc_busy_in_ack: got %b want 1", io_busy); else n_pass++;
    fdc_req = 1'b0;
    tick();
    seen_acsi |= acsi_ack;
    n_checks++; if (fdc_ack !== 1'b0) $display("FAIL fdc_ack_width: got %b want 0", fdc_ack); else n_pass++;
    n_checks++; if (io_busy !== 1'b0) $display("FAIL fdc_busy_after: got %b want 0", io_busy); else n_pass++;
    repeat (3) begin
      tick();
      seen_acsi |= acsi_ack;
    end
    n_checks++; if (seen_acsi !== 1'b0) $display("FAIL fdc_only_acsi_ack: got %b want 0", seen_acsi); else n_pass++;
    n_checks++; if (io_status !== 8'b0000_0100) $display("FAIL fdc_done_status: got %b want 00000100", io_status); else n_pass++;
  endtask

  task automatic test_stray_strobe();
    logic seen = 1'b0;
    io_strobe = 1'b1;
    tick();
    seen |= fdc_ack | acsi_ack;
    io_strobe = 1'b0;
    tick();
    seen |= fdc_ack | acsi_ack;
    n_checks++; if (seen !== 1'b0) $display("FAIL idle_strobe_ack: got %b want 0", seen); else n_pass++;
    fdc_req = 1'b1;
    tick();
    io_strobe = 1'b1;
    tick();
    n_checks++; if (fdc_ack !== 1'b1) $display("FAIL stray_setup_ack: got %b want 1", fdc_ack); else n_pass++;
    fdc_req = 1'b0;
    repeat (4) begin
      tick();
      seen |= fdc_ack | acsi_ack | (io_owner != 2'b00);
    end
    io_strobe = 1'b0;
    n_checks++; if (seen !== 1'b0) $display("FAIL holdoff_strobe_ack: got %b want 0", seen); else n_pass++;
  endtask

  task automatic test_round_robin();
    logic [1:0] order [3] = '{2'b01, 2'b10, 2'b01};
    int gap;
    reset = 1'b1;
    tick();
    reset = 1'b0; fdc_req = 1'b1; acsi_req = 1'b1;
    tick();
    for (int g = 0; g < 3; g++) begin
      n_checks++; if (io_owner !== order[g]) $display("FAIL rr_order[%0d]: got %b want %b", g, io_owner, order[g]); else n_pass++;
      io_strobe = 1'b1;
      tick();
      io_strobe = 1'b0;
      n_checks++;
      if ({fdc_ack, acsi_ack} !== {order[g] == 2'b01, order[g] == 2'b10})
        $display("FAIL rr_ack[%0d]: got fdc=%b acsi=%b for owner %b", g, fdc_ack, acsi_ack, order[g]);
      else n_pass++;
      if (g < 2) begin
        gap = 0;
        do begin
          tick();
          if (io_owner == 2'b00) gap++;
        end while (io_owner == 2'b00 && gap < 10);
        n_checks++; if (gap !== 3) $display("FAIL rr_gap[%0d]: got %0d idle cycles want 3", g, gap); else n_pass++;
      end
    end
    settle();
  endtask

  task automatic test_timeout();
    int cyc = 1;
    fdc_req = 1'b1;
    tick();
    n_checks++; if (io_owner !== 2'b01) $display("FAIL to_grant: got %b want 01", io_owner); else n_pass++;
    while (fdc_ack !== 1'b1 && cyc < 40) begin
      tick();
      cyc++;
    end
    n_checks++; if (cyc !== T + 1) $display("FAIL to_ack_cycle: got %0d want %0d", cyc, T + 1); else n_pass++;
    n_checks++; if (timeout_err !== 1'b1) $display("FAIL to_err_set: got %b want 1", timeout_err); else n_pass++;
    fdc_req = 1'b0;
    tick();
    n_checks++; if (timeout_err !== 1'b1) $display("FAIL to_err_sticky: got %b want 1", timeout_err); else n_pass++;
    repeat (3) tick();
    acsi_req = 1'b1;
    tick();
    n_checks++; if (io_owner !== 2'b10) $display("FAIL to_next_grant: got %b want 10", io_owner); else n_pass++;
    n_checks++; if (timeout_err !== 1'b0) $display("FAIL to_err_cleared: got %b want 0", timeout_err); else n_pass++;
    io_strobe = 1'b1;
    tick();
    io_strobe = 1'b0;
    acsi_req = 1'b0;
    settle();
  endtask

  task automatic test_req_drop();
    fdc_req = 1'b1;
    tick();
    n_checks++; if (io_owner !== 2'b01) $display("FAIL drop_grant: got %b want 01", io_owner); else n_pass++;
    acsi_req = 1'b1;
    tick(); tick();
    fdc_req = 1'b0;
    tick();
    n_checks++; if ({io_owner, io_busy} !== 3'b000) $display("FAIL drop_idle: got owner=%b busy=%b want 00/0", io_owner, io_busy); else n_pass++;
    n_checks++; if (fdc_ack !== 1'b0) $display("FAIL drop_no_ack: got %b want 0", fdc_ack); else n_pass++;
    n_checks++; if (io_status[3:2] !== 2'b10) $display("FAIL drop_last_owner: got %b want 10", io_status[3:2]); else n_pass++;
    tick();
    n_checks++; if (io_owner !== 2'b10) $display("FAIL drop_acsi_grant: got %b want 10", io_owner); else n_pass++;
    io_strobe = 1'b1;
    tick();
    io_strobe = 1'b0;
    n_checks++; if (acsi_ack !== 1'b1) $display("FAIL drop_acsi_ack: got %b want 1", acsi_ack); else n_pass++;
    acsi_req = 1'b0;
    settle();
  endtask

  task automatic test_reset_mid_grant();
    logic seen = 1'b0;
    fdc_req = 1'b1;
    tick();
    io_strobe = 1'b1;
    tick();
    io_strobe = 1'b0;
    repeat (4) tick();
    n_checks++; if (io_owner !== 2'b01) $display("FAIL rst_setup_regrant: got %b want 01", io_owner); else n_pass++;
    tick();
    reset = 1'b1; io_strobe = 1'b1;
    tick();
    n_checks++; if ({io_owner, io_busy, fdc_ack, acsi_ack, timeout_err} !== 6'b0)
      $display("FAIL rst_mid_outputs: got owner=%b busy=%b acks=%b%b terr=%b want all 0", io_owner, io_busy, fdc_ack, acsi_ack, timeout_err);
    else n_pass++;
    n_checks++; if (io_status !== 8'b0000_1000) $display("FAIL rst_mid_status: got %b want 00001000", io_status); else n_pass++;
    reset = 1'b0; io_strobe = 1'b0; fdc_req = 1'b0;
    repeat (3) begin
      tick();
      seen |= fdc_ack | acsi_ack;
    end
    n_checks++; if (seen !== 1'b0) $display("FAIL rst_mid_no_ack: got %b want 0", seen); else n_pass++;
    settle();
  endtask

  task automatic test_strobe_at_timeout();
    logic seen = 1'b0;
    acsi_req = 1'b1;
    tick();
    repeat (T - 1) begin
      tick();
      seen |= acsi_ack | fdc_ack;
    end
    n_checks++; if (seen !== 1'b0) $display("FAIL sto_early_ack: got %b want 0", seen); else n_pass++;
    io_strobe = 1'b1;
    tick();
    io_strobe = 1'b0;
    n_checks++; if (acsi_ack !== 1'b1) $display("FAIL sto_ack: got %b want 1", acsi_ack); else n_pass++;
    n_checks++; if (timeout_err !== 1'b0) $display("FAIL sto_terr: got %b want 0", timeout_err); else n_pass++;
    acsi_req = 1'b0;
    settle();
  endtask

  task automatic test_random();
    logic [12:0] exp_vec;
    logic [12:0] got_vec;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 7) == 0) fdc_req = ~fdc_req;
      if ($urandom_range(0, 7) == 0) acsi_req = ~acsi_req;
      io_strobe = ($urandom_range(0, 11) == 0);
      reset     = ($urandom_range(0, 249) == 0);
      tick();
      exp_vec = {2'(m_owner), m_owner != 0, m_ack == 1, m_ack == 2, m_terr, 2'(m_last)};
      exp_vec = {exp_vec[12:2], exp_vec[1:0]};
      got_vec = {io_owner, io_busy, fdc_ack, acsi_ack, timeout_err, io_status[3:2]};
      n_checks++;
      if (got_vec !== exp_vec || io_status[7:4] !== {io_busy, timeout_err, io_owner} || io_status[1:0] !== 2'b00)
        $display("FAIL random[%0d]: got owner=%b busy=%b ack=%b%b terr=%b status=%b want owner=%0d ack=%0d terr=%b last=%0d",
                 i, io_owner, io_busy, fdc_ack, acsi_ack, timeout_err, io_status, m_owner, m_ack, m_terr, m_last);
      else n_pass++;
    end
    reset = 1'b0; io_strobe = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fdc_only();
    test_stray_strobe();
    test_round_robin();
    test_timeout();
    test_req_drop();
    test_reset_mid_grant();
    test_strobe_at_timeout();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/dma_io_sched.md
# dma_io_sched

Scheduler that shares the single IO-controller transfer channel between the floppy controller and the ACSI hard-disk controller. Each requester raises a level request while it waits for the IO controller to move sector data. The block grants the channel to one requester at a time with round-robin fairness, publishes the owner to the IO controller, and returns a one-cycle `dma_ack` pulse to the owner when the IO controller strobes completion. It also enforces a timeout, so a hung IO controller cannot leave the FDC busy forever.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 8000000: cycles a grant may stay open before forced completion (1 s at 8 MHz).
- `TIMER_W`, default 24: width of the timeout counter; must hold `TIMEOUT_CYCLES`.

Ports:
- `clk`  in  1  system clock; one clock domain only.
- `reset`  in  1  synchronous, active-high reset.
- `fdc_req`  in  1  level; high while the FDC waits on the IO controller (its IO_WAIT state).
- `fdc_ack`  out  1  one-cycle pulse to the FDC `dma_ack`.
- `acsi_req`  in  1  level; high while ACSI waits on the IO controller.
- `acsi_ack`  out  1  one-cycle pulse to ACSI.
- `io_strobe`  in  1  one-cycle completion strobe from the IO controller.
- `io_owner`  out  2  current grant: 00 none, 01 FDC, 10 ACSI; 11 never driven.
- `io_busy`  out  1  high while a grant is open.
- `timeout_err`  out  1  sticky; set by a timeout, cleared at the next grant.
- `io_status`  out  8  `{io_busy, timeout_err, io_owner, last_owner, 2'b00}` for the IO controller to poll; `last_owner` is 2 bits, encoded like `io_owner`.

## Operation
- States: IDLE, GRANT, ACK, HOLDOFF.
- **IDLE**: if one request is high, grant it. If both are high, grant the requester that is not `last_owner`. After reset, `last_owner` = ACSI, so FDC wins the first tie. Granting loads `io_owner`, clears `timeout_err` and the timer, and goes to GRANT.
- **GRANT**:
  - The timer increments each cycle.
  - `io_strobe` goes to ACK.
  - Timer reaching `TIMEOUT_CYCLES-1` sets `timeout_err` and goes to ACK.
  - If the owner's request drops (for example an FDC force-interrupt), go to IDLE with no ack, set `io_owner` to 00, and leave `last_owner` unchanged.
- **ACK**: pulse the owner's ack for exactly one cycle, set `last_owner` = `io_owner`, go to HOLDOFF.
- **HOLDOFF**: held for 2 cycles with `io_owner` = 00, ignoring requests, so the acked requester can drop its level request. Then go to IDLE.
- Simultaneous events:
  - `io_strobe` and a request drop in the same GRANT cycle: the strobe wins and the ack is still issued. This is harmless; the FDC ignores `dma_ack` outside IO_WAIT.
  - `io_strobe` on the same cycle as the timeout: treated as a normal completion; `timeout_err` is not set.
- `io_strobe` in IDLE, ACK or HOLDOFF is ignored.
- A non-owner request arriving during GRANT is queued by its level and served after HOLDOFF.
- Reset, including mid-grant: state IDLE, `io_owner` 00, `io_busy` 0, both acks 0, `timeout_err` 0, `last_owner` 10, timer 0. No ack is emitted for an aborted grant.

## Timing
- A request sampled high in IDLE at edge N gives `io_owner`/`io_busy` valid after edge N+1.
- `io_strobe` high at edge M in GRANT gives the ack high during cycle M+1 only. `io_busy` falls after the ack cycle.
- Minimum request-to-request turnaround after an ack: 3 cycles (ACK + 2 HOLDOFF).
- Timeout ack appears `TIMEOUT_CYCLES`+1 cycles after the grant edge.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- The FDC register file updates on the negative edge. Its `dma_ack` input therefore sees the ack half a cycle after it rises, which is inside the one-cycle pulse window.

## Structure
- Shared package `dma_io_pkg`:
  - state encoding (2 bits);
  - owner codes `OWN_NONE`=00, `OWN_FDC`=01, `OWN_ACSI`=10;
  - `io_status` bit positions.
- One sub-module: `io_timeout_cnt`, a `TIMER_W`-bit counter with clear and enable inputs and an `expired` output at `TIMEOUT_CYCLES-1`.
- The FSM and round-robin logic stay in the top module.

## Test plan
- Only FDC requests, strobe 5 cycles after the grant:
  - `io_owner`=01 one cycle after the request.
  - `fdc_ack` high for exactly 1 cycle, one cycle after the strobe.
  - `acsi_ack` stays 0; `io_status`=8'b0000_0100 after completion.
- Both requests high from reset, strobe each grant:
  - grant order FDC, ACSI, FDC;
  - exactly 3 cycles of `io_owner`=00 between grants.
- Run with `TIMEOUT_CYCLES`=16:
  - FDC granted and no strobe: `fdc_ack` pulses 17 cycles after the grant, `timeout_err`=1.
  - Next grant clears `timeout_err`.
- FDC granted, `fdc_req` dropped at cycle 3:
  - back to IDLE, no ack, `last_owner` unchanged;
  - a pending `acsi_req` is granted the following cycle.
- `reset` asserted mid-GRANT:
  - next cycle all outputs at reset values;
  - a strobe in the same cycle produces no ack.
- Edge cases:
  - `io_strobe` in IDLE and during HOLDOFF produces no ack.
  - Strobe coincident with the timeout cycle acks with `timeout_err`=0.
